split_check_seq: RTL

- Sequential, parametrised successor to the generated per-split constraint blocks of the BDD solver.
- The existing blocks take every variable in parallel and drive a constant verdict.
- This block receives the variables of one candidate assignment as a stream, one variable per beat.
- It evaluates a selectable constraint mode and returns a single verdict `x` through a result handshake. The solver front end sits upstream; the BDD merge/accumulate stage sits downstream.

---
 rtl/split_check_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/split_check_seq.sv
// Streaming constraint checker: accepts one variable per beat, evaluates the
// selected constraint mode over a frame and returns one verdict per frame.
module split_check_seq #(
  parameter int NUM_VARS = 150,
  parameter int DATA_W   = 16,
  parameter int MODE     = 0,
  parameter int SUM_W    = DATA_W + $clog2(NUM_VARS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  input  logic [DATA_W-1:0] cfg_lo,
  input  logic [DATA_W-1:0] cfg_hi,
  input  logic [SUM_W-1:0]  cfg_sum_max,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              x,
  output logic              err,
  output logic [15:0]       frame_cnt
);

  localparam int IDX_W  = $clog2(NUM_VARS);
  localparam int SUMX_W = SUM_W + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VARS - 1);
  localparam logic [1:0] MODE_SEL = 2'(MODE);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               init_q;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               pass_q, pass_d;
  logic [SUM_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  lo_q, lo_d, hi_q, hi_d;
  logic [SUM_W-1:0]   smax_q, smax_d;
  logic               x_q, x_d, err_q, err_d;
  logic [15:0]        cnt_q, cnt_d;

  logic               fire_s, first_s, in_rng_s, pass_new_s, mode_ok_s;
  logic               frame_end_s, len_ok_s;
  logic [IDX_W-1:0]   idx_cur_s;
  logic               pass_cur_s;
  logic [SUM_W-1:0]   acc_cur_s, acc_new_s, smax_cur_s;
  logic [DATA_W-1:0]  lo_cur_s, hi_cur_s;
  logic [SUMX_W-1:0]  sum_ext_s;

  assign in_ready  = init_q & (state_q != S_DONE);
  assign res_valid = (state_q == S_DONE);
  assign x         = x_q;
  assign err       = err_q;
  assign frame_cnt = cnt_q;

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      init_q  <= 1'b0;
      idx_q   <= {IDX_W{1'b0}};
      pass_q  <= 1'b1;
      acc_q   <= {SUM_W{1'b0}};
      lo_q    <= {DATA_W{1'b0}};
      hi_q    <= {DATA_W{1'b0}};
      smax_q  <= {SUM_W{1'b0}};
      x_q     <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
      idx_q   <= idx_d;
      pass_q  <= pass_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      smax_q  <= smax_d;
      x_q     <= x_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Beat evaluation: the first beat of a frame works from fresh state and live cfg
  always_comb begin
    fire_s      = in_valid & in_ready;
    first_s     = (state_q == S_IDLE);
    idx_cur_s   = first_s ? {IDX_W{1'b0}} : idx_q;
    pass_cur_s  = first_s ? 1'b1 : pass_q;
    acc_cur_s   = first_s ? {SUM_W{1'b0}} : acc_q;
    lo_cur_s    = first_s ? cfg_lo : lo_q;
    hi_cur_s    = first_s ? cfg_hi : hi_q;
    smax_cur_s  = first_s ? cfg_sum_max : smax_q;
    in_rng_s    = (in_data >= lo_cur_s) && (in_data <= hi_cur_s);
    pass_new_s  = pass_cur_s & in_rng_s;
    sum_ext_s   = {1'b0, acc_cur_s} + SUMX_W'(in_data);
    acc_new_s   = sum_ext_s[SUM_W] ? {SUM_W{1'b1}} : sum_ext_s[SUM_W-1:0];
    frame_end_s = in_last | (idx_cur_s == LAST_IDX);
    len_ok_s    = in_last & (idx_cur_s == LAST_IDX);
    case (MODE_SEL)
      2'd0:    mode_ok_s = 1'b1;
      2'd1:    mode_ok_s = pass_new_s;
      2'd2:    mode_ok_s = (acc_new_s <= smax_cur_s);
      default: mode_ok_s = 1'b0;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pass_d  = pass_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    smax_d  = smax_q;
    x_d     = x_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (fire_s) begin
          lo_d   = lo_cur_s;
          hi_d   = hi_cur_s;
          smax_d = smax_cur_s;
          idx_d  = idx_cur_s + IDX_W'(1);
          pass_d = pass_new_s;
          acc_d  = acc_new_s;
          if (frame_end_s) begin
            state_d = S_DONE;
            x_d     = len_ok_s & mode_ok_s;
            err_d   = ~len_ok_s;
          end else begin
            state_d = S_COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
          cnt_d   = cnt_q + 16'd1;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule
